phaser_out_dly_ctrl: RTL and testbench

//  Upstream tap controller for PHASER_OUT; sits in the same clock domain as its control inputs.

---
 rtl/phaser_out_dly_ctrl_pkg.sv | 29 ++
 rtl/phaser_out_gap_timer.sv | 32 +++
 rtl/phaser_out_dly_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_phaser_out_dly_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/phaser_out_dly_ctrl_pkg.sv
// Shared types and helpers for the PHASER_OUT tap controller.
// Build option: PHASER_OUT_DLY_CTRL_READBACK_EN adds the counter-readback states.
package phaser_out_dly_ctrl_pkg;

  localparam int unsigned TAP_W = 6;  // fine/coarse tap counter width
  localparam int unsigned CNT_W = 9;  // PHASER_OUT COUNTERREADVAL width
  localparam int unsigned GAP_W = 8;  // settle-gap timer width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FINE_STEP,
    ST_FINE_WAIT,
    ST_CRS_STEP,
    ST_CRS_WAIT,
`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
    ST_RB_REQ,
    ST_RB_WAIT,
    ST_RB_CHK,
`endif
    ST_FIN
  } state_t;

  // Limit a requested tap to the highest legal tap.
  function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] v,
                                                 input logic [TAP_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/phaser_out_gap_timer.sv
// Down-counter used to time the settle gap between tap steps and the
// readback wait.
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_load     load i_load_val (takes priority over counting)
//   i_load_val value loaded; o_expired rises i_load_val+1 cycles after load
//   o_expired  counter is at zero
module phaser_out_gap_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/phaser_out_dly_ctrl.sv
// PHASER_OUT tap controller: accepts a fine/coarse tap target and walks
// PHASER_OUT one tap at a time (fine first, then coarse) with a settle gap
// of STEP_GAP cycles between strobes. Tracks current taps, pulses DONE when
// a request finishes or aborts, and keeps a sticky ERR on overflow.
// Build option: PHASER_OUT_DLY_CTRL_READBACK_EN adds a COUNTERREADVAL check
// of the fine tap after the coarse walk.
// Ports:
//   SYSCLK, RST                       clock, synchronous active-high reset
//   REQ_VALID/REQ_READY               request handshake
//   REQ_FINE, REQ_COARSE              tap targets (clamped to TAP_MAX)
//   DONE, ERR                         completion pulse, sticky error
//   CUR_FINE, CUR_COARSE              tracked tap counts
//   FINEENABLE/FINEINC                fine step strobe and direction
//   COARSEENABLE/COARSEINC            coarse step strobe and direction
//   FINEOVERFLOW, COARSEOVERFLOW      PHASER_OUT overflow flags
//   COUNTERREADEN, COUNTERREADVAL     counter readback
module phaser_out_dly_ctrl
  import phaser_out_dly_ctrl_pkg::*;
#(
  parameter int unsigned FINE_INIT   = 0,
  parameter int unsigned COARSE_INIT = 0,
  parameter int unsigned TAP_MAX     = 63,
  parameter int unsigned STEP_GAP    = 8
) (
  input  logic             SYSCLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [TAP_W-1:0] REQ_FINE,
  input  logic [TAP_W-1:0] REQ_COARSE,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_FINE,
  output logic [TAP_W-1:0] CUR_COARSE,
  output logic             FINEENABLE,
  output logic             FINEINC,
  output logic             COARSEENABLE,
  output logic             COARSEINC,
  input  logic             FINEOVERFLOW,
  input  logic             COARSEOVERFLOW,
  output logic             COUNTERREADEN,
  input  logic [CNT_W-1:0] COUNTERREADVAL
);

  localparam logic [TAP_W-1:0] FINE_INIT_L   = TAP_W'(FINE_INIT);
  localparam logic [TAP_W-1:0] COARSE_INIT_L = TAP_W'(COARSE_INIT);
  localparam logic [TAP_W-1:0] TAP_MAX_L     = TAP_W'(TAP_MAX);
  localparam logic [GAP_W-1:0] GAP_LOAD      = GAP_W'(STEP_GAP - 2);

  state_t           r_state, w_next;
  logic [TAP_W-1:0] r_fine, r_crs, r_tgt_fine, r_tgt_crs;
  logic             r_err;

  logic             w_accept, w_fine_en, w_crs_en, w_done, w_rd_en, w_err_set;
  logic             w_load, w_expired, w_ovf, w_fine_up, w_crs_up;
  logic             w_fine_match, w_crs_match;
  logic [GAP_W-1:0] w_load_val;

  assign w_ovf        = FINEOVERFLOW | COARSEOVERFLOW;
  assign w_fine_match = (r_fine == r_tgt_fine);
  assign w_crs_match  = (r_crs == r_tgt_crs);
  assign w_fine_up    = (r_tgt_fine > r_fine);
  assign w_crs_up     = (r_tgt_crs > r_crs);

  phaser_out_gap_timer #(.W(GAP_W)) u_gap (
    .i_clk      (SYSCLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  // All strobes are gated in the RST cycle so PHASER_OUT never steps
  // without CUR_* following.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fine_en  = 1'b0;
    w_crs_en   = 1'b0;
    w_done     = 1'b0;
    w_rd_en    = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    w_err_set  = 1'b0;
    if (RST) begin
      w_next = ST_IDLE;
    end else begin
      w_err_set = (r_state != ST_IDLE) && w_ovf;
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            w_accept = 1'b1;
            w_next   = ST_FINE_STEP;
          end
        end
        // Matched fine falls through to the coarse check in the same cycle;
        // in CRS_STEP the fine tap always matches.
        ST_FINE_STEP, ST_CRS_STEP: begin
          if (w_ovf) begin
            w_next = ST_FIN;
          end else if (!w_fine_match) begin
            w_fine_en  = 1'b1;
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
            w_next     = ST_FINE_WAIT;
          end else if (!w_crs_match) begin
            w_crs_en   = 1'b1;
            w_load     = 1'b1;
            w_load_val = GAP_LOAD;
            w_next     = ST_CRS_WAIT;
          end else begin
`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
            w_next = ST_RB_REQ;
`else
            w_done = 1'b1;
            w_next = ST_IDLE;
`endif
          end
        end
        ST_FINE_WAIT: begin
          if (w_ovf)          w_next = ST_FIN;
          else if (w_expired) w_next = ST_FINE_STEP;
        end
        ST_CRS_WAIT: begin
          if (w_ovf)          w_next = ST_FIN;
          else if (w_expired) w_next = ST_CRS_STEP;
        end
`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
        ST_RB_REQ: begin
          if (w_ovf) begin
            w_next = ST_FIN;
          end else begin
            w_rd_en    = 1'b1;
            w_load     = 1'b1;
            w_load_val = GAP_W'(1);
            w_next     = ST_RB_WAIT;
          end
        end
        ST_RB_WAIT: begin
          if (w_ovf)          w_next = ST_FIN;
          else if (w_expired) w_next = ST_RB_CHK;
        end
        ST_RB_CHK: begin
          if (w_ovf) begin
            w_next = ST_FIN;
          end else begin
            w_done    = 1'b1;
            w_err_set = (COUNTERREADVAL[TAP_W-1:0] != r_fine);
            w_next    = ST_IDLE;
          end
        end
`endif
        ST_FIN: begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_fine     <= FINE_INIT_L;
      r_crs      <= COARSE_INIT_L;
      r_tgt_fine <= FINE_INIT_L;
      r_tgt_crs  <= COARSE_INIT_L;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tgt_fine <= clamp_tap(REQ_FINE, TAP_MAX_L);
        r_tgt_crs  <= clamp_tap(REQ_COARSE, TAP_MAX_L);
      end
      if (w_fine_en) begin
        if (w_fine_up && r_fine != TAP_MAX_L) r_fine <= r_fine + TAP_W'(1);
        else if (!w_fine_up && r_fine != '0)  r_fine <= r_fine - TAP_W'(1);
      end
      if (w_crs_en) begin
        if (w_crs_up && r_crs != TAP_MAX_L)   r_crs <= r_crs + TAP_W'(1);
        else if (!w_crs_up && r_crs != '0)    r_crs <= r_crs - TAP_W'(1);
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
  logic [CNT_W-TAP_W-1:0] w_unused_rb_hi;
  assign w_unused_rb_hi = COUNTERREADVAL[CNT_W-1:TAP_W];
  assign COUNTERREADEN  = w_rd_en;
`else
  logic w_unused_rb;
  assign w_unused_rb   = ^{COUNTERREADVAL, w_rd_en};
  assign COUNTERREADEN = 1'b0;
`endif

  assign REQ_READY    = (r_state == ST_IDLE);
  assign DONE         = w_done;
  assign ERR          = r_err;
  assign CUR_FINE     = r_fine;
  assign CUR_COARSE   = r_crs;
  assign FINEENABLE   = w_fine_en;
  assign FINEINC      = w_fine_en & w_fine_up;
  assign COARSEENABLE = w_crs_en;
  assign COARSEINC    = w_crs_en & w_crs_up;

endmodule

// File: tb/tb_phaser_out_dly_ctrl.sv
// Scoreboard bench for phaser_out_dly_ctrl. The driver pushes expected
// strobe/DONE events (absolute cycle, direction, final taps); a negedge
// monitor pops one entry per DUT strobe or DONE and compares.
module tb_phaser_out_dly_ctrl;

  localparam int GAP  = 8;
  localparam int TMAX = 40;
`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
  localparam int RB_LAT = 4;
`else
  localparam int RB_LAT = 0;
`endif
  localparam int K_FINE = 0, K_CRS = 1, K_DONE = 2;

  typedef struct {
    int cyc; int kind; int inc; int f; int c; int err;
  } exp_t;

  logic       SYSCLK = 1'b0;
  logic       RST, REQ_VALID, REQ_READY, DONE, ERR;
  logic [5:0] REQ_FINE, REQ_COARSE, CUR_FINE, CUR_COARSE;
  logic       FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
  logic       FINEOVERFLOW, COARSEOVERFLOW, COUNTERREADEN;
  logic [8:0] COUNTERREADVAL;

  exp_t q[$];
  int   total = 0, bad = 0, ncyc = 0;
  int   mf = 0, mc = 0, merr = 0;
  int   t0;

  phaser_out_dly_ctrl #(
    .FINE_INIT(0), .COARSE_INIT(0), .TAP_MAX(TMAX), .STEP_GAP(GAP)
  ) dut (
    .SYSCLK(SYSCLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_FINE(REQ_FINE), .REQ_COARSE(REQ_COARSE), .DONE(DONE), .ERR(ERR),
    .CUR_FINE(CUR_FINE), .CUR_COARSE(CUR_COARSE),
    .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
    .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
    .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW),
    .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic push(input int cyc, input int kind, input int inc,
                      input int f, input int c, input int err);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.inc = inc; e.f = f; e.c = c; e.err = err;
    q.push_back(e);
  endtask

  task automatic got(input int kind, input int inc);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", ncyc, e.cyc);
      if (kind == K_DONE) begin
        chk("done_cur_fine", int'(CUR_FINE), e.f);
        chk("done_cur_coarse", int'(CUR_COARSE), e.c);
        chk("done_err", int'(ERR), e.err);
      end else begin
        chk("step_inc", inc, e.inc);
      end
    end
  endtask

  // Monitor: ncyc is the cycle index counted from negedges.
  always @(negedge SYSCLK) begin
    ncyc++;
    if (FINEENABLE)   got(K_FINE, int'(FINEINC));
    if (COARSEENABLE) got(K_CRS, int'(COARSEINC));
    if (DONE)         got(K_DONE, 0);
  end

  // Expected walk: one strobe per tap, GAP cycles apart, starting in cycle 1.
  task automatic plan(input int ts, input int f, input int c);
    int tf, tc, k;
    tf = (f > TMAX) ? TMAX : f;
    tc = (c > TMAX) ? TMAX : c;
    k  = 1;
    while (mf != tf) begin
      push(ts + k, K_FINE, (tf > mf) ? 1 : 0, 0, 0, 0);
      mf += (tf > mf) ? 1 : -1;
      k  += GAP;
    end
    while (mc != tc) begin
      push(ts + k, K_CRS, (tc > mc) ? 1 : 0, 0, 0, 0);
      mc += (tc > mc) ? 1 : -1;
      k  += GAP;
    end
    push(ts + k + RB_LAT, K_DONE, 0, mf, mc, merr);
  endtask

  task automatic issue(input int f, input int c, input int rb, output int ts);
    int n = 0;
    while (!REQ_READY && n < 1000) begin
      @(posedge SYSCLK); #2; n++;
    end
    chk("ready_before_req", int'(REQ_READY), 1);
    REQ_VALID = 1'b1; REQ_FINE = 6'(f); REQ_COARSE = 6'(c);
    COUNTERREADVAL = 9'(rb);
    @(posedge SYSCLK);
    ts = ncyc;
    #2 REQ_VALID = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge SYSCLK); #2; n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge SYSCLK); #2;
    RST = 1'b0;
    mf = 0; mc = 0; merr = 0;
    chk("rst_ready", int'(REQ_READY), 1);
    chk("rst_err", int'(ERR), 0);
    chk("rst_cur_fine", int'(CUR_FINE), 0);
    chk("rst_cur_coarse", int'(CUR_COARSE), 0);
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_FINE = '0; REQ_COARSE = '0;
    FINEOVERFLOW = 1'b0; COARSEOVERFLOW = 1'b0; COUNTERREADVAL = '0;
    repeat (3) @(posedge SYSCLK);
    #2 RST = 1'b0;
    chk("init_ready", int'(REQ_READY), 1);
    chk("init_done", int'(DONE), 0);
    chk("init_err", int'(ERR), 0);
    chk("init_fineen", int'(FINEENABLE), 0);
    chk("init_crsen", int'(COARSEENABLE), 0);
    chk("init_fineinc", int'(FINEINC), 0);
    chk("init_cur_fine", int'(CUR_FINE), 0);
    chk("init_cur_coarse", int'(CUR_COARSE), 0);
    chk("init_rden", int'(COUNTERREADEN), 0);

    // 1: fine 0->5, DONE at cycle 41
    issue(5, 0, 5, t0); plan(t0, 5, 0); drain(200);
    // 2: fine 5->2 dec, coarse 0->3 inc, DONE at cycle 49
    issue(2, 3, 2, t0); plan(t0, 2, 3); drain(200);
    // 3: zero-step request
    issue(2, 3, 2, t0); plan(t0, 2, 3);
    chk("t3_ready_cycle1", int'(REQ_READY), 0);
    @(posedge SYSCLK); #2;
    chk("t3_ready_cycle2", int'(REQ_READY), (RB_LAT == 0) ? 1 : 0);
    drain(50);

    // 4: overflow in cycle 12 (2nd FINE_WAIT) aborts after two fine steps
    issue(10, 3, 10, t0);
    push(t0 + 1, K_FINE, 1, 0, 0, 0);
    push(t0 + 9, K_FINE, 1, 0, 0, 0);
    push(t0 + 13, K_DONE, 0, 4, 3, 1);
    mf = 4; merr = 1;
    repeat (11) @(posedge SYSCLK);
    #2 FINEOVERFLOW = 1'b1;
    @(posedge SYSCLK);
    #2 FINEOVERFLOW = 1'b0;
    drain(50);
    repeat (5) @(posedge SYSCLK);
    #2 chk("t4_err_sticky", int'(ERR), 1);
    do_reset();

    // 5: reset during the 3rd fine step of a 10-tap walk
    issue(10, 0, 10, t0);
    push(t0 + 1, K_FINE, 1, 0, 0, 0);
    push(t0 + 9, K_FINE, 1, 0, 0, 0);
    repeat (16) @(posedge SYSCLK);
    #2 RST = 1'b1;
    @(posedge SYSCLK);
    #2 RST = 1'b0;
    chk("t5_ready", int'(REQ_READY), 1);
    chk("t5_cur_fine", int'(CUR_FINE), 0);
    chk("t5_fineen", int'(FINEENABLE), 0);
    mf = 0;
    // request during reset is ignored
    RST = 1'b1; REQ_VALID = 1'b1; REQ_FINE = 6'd3;
    @(posedge SYSCLK);
    #2 RST = 1'b0; REQ_VALID = 1'b0;
    chk("rstreq_ready", int'(REQ_READY), 1);
    repeat (20) @(posedge SYSCLK);
    #2 chk("rstreq_cur_fine", int'(CUR_FINE), 0);
    drain(10);

    // 6: request above TAP_MAX clamps to 40
    issue(50, 0, 40, t0); plan(t0, 50, 0); drain(500);
    // 7: fine dec with coarse inc, then coarse dec
    issue(38, 5, 38, t0); plan(t0, 38, 5); drain(200);
    issue(38, 1, 38, t0); plan(t0, 38, 1); drain(200);

`ifdef PHASER_OUT_DLY_CTRL_READBACK_EN
    // 8: readback match then mismatch
    do_reset();
    issue(7, 0, 7, t0); plan(t0, 7, 0); drain(200);
    chk("rb_match_err", int'(ERR), 0);
    issue(7, 0, 6, t0); plan(t0, 7, 0); drain(50);
    chk("rb_mismatch_err", int'(ERR), 1);
`else
    chk("rden_tied_low", int'(COUNTERREADEN), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected finish", ncyc);
    $fatal(1);
  end

endmodule
